if_id_buffer: RTL

Instruction prefetch queue between fetch_stage and decode_stage, holding {pc, instruction} pairs. Fetch can run ahead while decode is stalled. A branch redirect from execute flushes every entry in one cycle. Valid/ready handshake on both sides, circular buffer of DEPTH entries.

---
 rtl/if_id_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// Fetch-to-decode prefetch queue: circular buffer of {pc, instruction} pairs
// with valid/ready on both sides and a single-cycle flush on branch redirect.
module if_id_buffer #(
   parameter int                 DEPTH   = 4,
   parameter int                 PC_W    = 64,
   parameter int                 INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP     = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PC_W-1:0]           in_pc,
   input  logic [INSTR_W-1:0]        in_instr,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PC_W-1:0]           out_pc,
   output logic [INSTR_W-1:0]        out_instr,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];

   logic push;
   logic pop;

   // in_ready deliberately ignores out_ready: a full queue never takes a
   // push in the same cycle it drains, which keeps the ready path short.
   assign in_ready  = (count_q < FULL_CNT) & ~flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
   assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; the count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= in_pc;
         instr_mem[wr_ptr_q] <= in_instr;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (count_q <= FULL_CNT)
            else $error("if_id_buffer: count overflow %0d", count_q);
         assert (!(pop && !push && !flush && count_q == '0))
            else $error("if_id_buffer: count underflow");
      end
   end
`endif

endmodule
